// File: rtl/register_file.sv
// register_file: Y86-64 architectural register file.
// Fifteen DATA_W-bit program registers (IDs 0x0-0xE); ID 0xF (RNONE) means
// "no register" on every read and write port and always reads as zero.
// Two combinational read ports (srcA/srcB) plus a debug read port, and two
// write-back ports (dstE/valE, dstM/valM) committed on the rising clock edge
// when wb_en is high. On a dstE/dstM collision the M-port data wins.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read
// forwarding from the write-back ports onto valA/valB/dbg_val.
module register_file #(
    parameter int unsigned          DATA_W   = 64,
    parameter logic [DATA_W-1:0]    RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    input  logic [3:0]        dbg_id,
    output logic [DATA_W-1:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [DATA_W-1:0] r_regs [0:14];

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_rd_dbg;

    // Write-back and reset: reset dominates; the M-port write is issued last so it wins a collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 15; i++) begin
                r_regs[i[3:0]] <= (i[3:0] == RRSP) ? RSP_INIT : '0;
            end
        end else if (wb_en) begin
            if (dstE != RNONE) begin
                r_regs[dstE] <= valE;
            end
            if (dstM != RNONE) begin
                r_regs[dstM] <= valM;
            end
        end
    end

    // Stored-value lookup for the three read ports; RNONE reads as zero
    always_comb begin
        w_rd_a   = '0;
        w_rd_b   = '0;
        w_rd_dbg = '0;
        if (srcA != RNONE) begin
            w_rd_a = r_regs[srcA];
        end
        if (srcB != RNONE) begin
            w_rd_b = r_regs[srcB];
        end
        if (dbg_id != RNONE) begin
            w_rd_dbg = r_regs[dbg_id];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_en;
    assign w_fwd_en = wb_en && !reset;

    // Forward pending write-back data to matching reads; M-port has priority as in the write path
    always_comb begin
        valA    = w_rd_a;
        valB    = w_rd_b;
        dbg_val = w_rd_dbg;
        if (w_fwd_en) begin
            if (srcA != RNONE && srcA == dstM) begin
                valA = valM;
            end else if (srcA != RNONE && srcA == dstE) begin
                valA = valE;
            end
            if (srcB != RNONE && srcB == dstM) begin
                valB = valM;
            end else if (srcB != RNONE && srcB == dstE) begin
                valB = valE;
            end
            if (dbg_id != RNONE && dbg_id == dstM) begin
                dbg_val = valM;
            end else if (dbg_id != RNONE && dbg_id == dstE) begin
                dbg_val = valE;
            end
        end
    end
`else
    // Reads reflect stored contents only
    always_comb begin
        valA    = w_rd_a;
        valB    = w_rd_b;
        dbg_val = w_rd_dbg;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scoreboard bench for register_file.
// Stimulus drives one vector per cycle and pushes the hand-computed read
// results; a monitor pops and compares on the falling edge.
module tb_register_file;

    localparam int unsigned       DW  = 64;
    localparam logic [DW-1:0]     RSP = 64'h200;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    srcA, srcB, dstE, dstM, dbg_id;
    logic [DW-1:0] valA, valB, valE, valM, dbg_val;
    logic          wb_en;

    typedef struct {
        string         name;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    register_file #(.DATA_W(DW), .RSP_INIT(RSP)) dut (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .wb_en(wb_en), .dbg_id(dbg_id), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic wb,
                        input logic [3:0] sa, input logic [3:0] sbid, input logic [3:0] dg,
                        input logic [3:0] de, input logic [DW-1:0] ve,
                        input logic [3:0] dm, input logic [DW-1:0] vm);
        @(posedge clk);
        #1;
        reset  = rst;  wb_en = wb;
        srcA   = sa;   srcB  = sbid; dbg_id = dg;
        dstE   = de;   valE  = ve;
        dstM   = dm;   valM  = vm;
    endtask

    task automatic expect_rd(input string nm, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] d);
        exp_t e;
        e.name = nm; e.a = a; e.b = b; e.d = d;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry is consumed per falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (valA !== e.a) begin
                n_fail++;
                $display("FAIL %s valA: got %h expected %h", e.name, valA, e.a);
            end
            n_checks++;
            if (valB !== e.b) begin
                n_fail++;
                $display("FAIL %s valB: got %h expected %h", e.name, valB, e.b);
            end
            n_checks++;
            if (dbg_val !== e.d) begin
                n_fail++;
                $display("FAIL %s dbg_val: got %h expected %h", e.name, dbg_val, e.d);
            end
        end
    end

    initial begin
        reset = 1'b1; wb_en = 1'b0;
        srcA = 4'hF; srcB = 4'hF; dbg_id = 4'hF;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;

        // Reset state: sweep every ID, RNONE on port B
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, i[3:0], 4'hF, i[3:0], 4'hF, '0, 4'hF, '0);
            expect_rd($sformatf("reset_id%0d", i),
                      (i == 4) ? RSP : 64'h0, 64'h0, (i == 4) ? RSP : 64'h0);
        end

        // Dual write to distinct registers
        step(1'b0, 1'b1, 4'h2, 4'h3, 4'hF, 4'h2, 64'h11, 4'h3, 64'h22);
        expect_rd("dual_wr_same_cycle", BYP ? 64'h11 : 64'h0, BYP ? 64'h22 : 64'h0, 64'h0);
        step(1'b0, 1'b1, 4'h2, 4'h3, 4'h2, 4'hF, '0, 4'hF, '0);
        expect_rd("dual_wr_after", 64'h11, 64'h22, 64'h11);

        // Collision on %rsp: valM wins
        step(1'b0, 1'b1, 4'h4, 4'hF, 4'h4, 4'h4, 64'h1F8, 4'h4, 64'hABCD);
        expect_rd("rsp_collide_same", BYP ? 64'hABCD : RSP, 64'h0, BYP ? 64'hABCD : RSP);
        step(1'b0, 1'b1, 4'h4, 4'hF, 4'h4, 4'hF, '0, 4'hF, '0);
        expect_rd("rsp_collide_after", 64'hABCD, 64'h0, 64'hABCD);

        // wb_en low blocks writes
        step(1'b0, 1'b0, 4'h1, 4'hF, 4'h1, 4'h1, 64'hFF, 4'hF, '0);
        expect_rd("wben0_same", 64'h0, 64'h0, 64'h0);
        // Both destinations RNONE with wb_en high: no change
        step(1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'hF, 64'h5, 4'hF, 64'h6);
        expect_rd("wben0_after", 64'h0, 64'h11, 64'h22);
        step(1'b0, 1'b0, 4'h1, 4'h2, 4'h3, 4'hF, '0, 4'hF, '0);
        expect_rd("both_none_after", 64'h0, 64'h11, 64'h22);

        // Reset coincident with a write: write dropped, state cleared
        step(1'b1, 1'b1, 4'h5, 4'h2, 4'h4, 4'h5, 64'h77, 4'hF, '0);
        expect_rd("reset_wr_same", 64'h0, 64'h11, 64'hABCD);
        step(1'b0, 1'b0, 4'h5, 4'h2, 4'h4, 4'hF, '0, 4'hF, '0);
        expect_rd("reset_wr_after", 64'h0, 64'h0, RSP);

        // Same-cycle read of written IDs
        step(1'b0, 1'b1, 4'h6, 4'h7, 4'hF, 4'h6, 64'h99, 4'h7, 64'hAA);
        expect_rd("rw_same_cycle", BYP ? 64'h99 : 64'h0, BYP ? 64'hAA : 64'h0, 64'h0);
        step(1'b0, 1'b1, 4'h6, 4'h7, 4'h6, 4'hF, '0, 4'hF, '0);
        expect_rd("rw_after", 64'h99, 64'hAA, 64'h99);

        // Collision on a general register, read in the same cycle
        step(1'b0, 1'b1, 4'h8, 4'h6, 4'h8, 4'h8, 64'h1, 4'h8, 64'h2);
        expect_rd("collide8_same", BYP ? 64'h2 : 64'h0, 64'h99, BYP ? 64'h2 : 64'h0);
        step(1'b0, 1'b1, 4'h8, 4'hF, 4'h8, 4'hF, '0, 4'hF, '0);
        expect_rd("collide8_after", 64'h2, 64'h0, 64'h2);

        // Boundary IDs 0x0 and 0xE
        step(1'b0, 1'b1, 4'hE, 4'h0, 4'hF, 4'hE, 64'hDEAD, 4'h0, 64'hCAFE);
        expect_rd("edge_ids_same", BYP ? 64'hDEAD : 64'h0, BYP ? 64'hCAFE : 64'h0, 64'h0);
        step(1'b0, 1'b0, 4'hE, 4'h0, 4'hF, 4'hF, '0, 4'hF, '0);
        expect_rd("edge_ids_after", 64'hDEAD, 64'hCAFE, 64'h0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Y86-64 architectural register file: fifteen 64-bit program registers (IDs 0x0–0xE), read by decode through the srcA/srcB ports and written at the end of each instruction by write-back through the dstE/dstM ports. Register ID 0xF (RNONE) means "no register" on every port. The block is the consumer of the write-back destination selection and the source of valA/valB for the decode/execute path of the SEQ processor.

## Interface

Parameters:
- `DATA_W`, 64: register width in bits.
- `RSP_INIT`, 64'h0: reset value of %rsp (ID 0x4); every other register resets to 0.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `srcA`  input  4  read-port A register ID; 0xF = none.
- `srcB`  input  4  read-port B register ID; 0xF = none.
- `valA`  output  DATA_W  contents of `srcA`; 0 when `srcA` = 0xF.
- `valB`  output  DATA_W  contents of `srcB`; 0 when `srcB` = 0xF.
- `dstE`  input  4  E-port write ID; 0xF = no write.
- `valE`  input  DATA_W  E-port write data (ALU result).
- `dstM`  input  4  M-port write ID; 0xF = no write.
- `valM`  input  DATA_W  M-port write data (memory read).
- `wb_en`  input  1  write-back commit; writes happen only when high (low during stall/halt/exception).
- `dbg_id`  input  4  debug read ID.
- `dbg_val`  output  DATA_W  contents of `dbg_id`; 0 when 0xF.

## Operation

- Storage: 15 × DATA_W registers; no physical entry for ID 0xF.
- Reads: valA, valB, dbg_val are combinational functions of the ID and current register contents (plus bypass, see Configuration).
- Writes on rising `clk` when `reset`=0 and `wb_en`=1:
  - `dstE` ≠ 0xF → reg[dstE] ← valE.
  - `dstM` ≠ 0xF → reg[dstM] ← valM.
  - `dstE` = `dstM` ≠ 0xF → valM wins (popq %rsp semantics); valE discarded.
  - Both 0xF → no state change.
- `wb_en`=0 → no register changes regardless of dstE/dstM.
- Reset: on rising `clk` with `reset`=1, all registers ← 0 except %rsp ← RSP_INIT; reset overrides any simultaneous write.

## Timing

- Read latency: zero cycles (combinational); write visible to reads the cycle after the committing edge.
- Reset value of outputs: after the reset edge, valA/valB/dbg_val = 0 for every ID except 0x4 → RSP_INIT; 0xF → 0 always.
- Reset asserted mid-operation: pending write of that edge is dropped; writes resume on the first edge with `reset`=0.
- Read and write of same ID in the same cycle (no bypass): read returns old value.
- Out-of-range IDs do not exist (4-bit ID, 0xF reserved); no X may reach outputs for any ID.

## Configuration

- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read forwarding. If `wb_en`=1 and a read ID matches a non-0xF `dstM`, output valM; else if it matches `dstE`, output valE; else stored value. Not applied while `reset`=1. Applies to valA, valB, dbg_val.
- Not defined: reads return stored contents only; no combinational path from valE/valM/dstE/dstM/wb_en to outputs.

## Test plan

- Reset with RSP_INIT=64'h200 → all IDs read 0, ID 0x4 reads 64'h200, ID 0xF reads 0.
- wb_en=1, dstE=0x2, valE=64'h11, dstM=0x3, valM=64'h22 → next cycle srcA=2 gives 64'h11, srcB=3 gives 64'h22.
- dstE=dstM=0x4, valE=64'h1F8, valM=64'hABCD, wb_en=1 → %rsp reads 64'hABCD.
- wb_en=0, dstE=0x1, valE=64'hFF → reg 1 unchanged; dstE=dstM=0xF with wb_en=1 → no register changes.
- reset=1 coincident with write dstE=0x5, valE=64'h77 → reg 5 reads 0 after edge.
- Same-cycle write dstE=0x6, valE=64'h99, srcA=6: with REGFILE_BYPASS_EN valA=64'h99 before edge; without it valA = old value until after edge.
